// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory bus bundle for imem_loader.
// slave  : the loader side (consumes bytes, drives the memory write port)
// master : the host/memory side (supplies bytes, observes the write port)
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_a, mem_d, mem_we
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_a, mem_d, mem_we
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the MIPS instruction memory.
// Stream: length byte N (0 means DEPTH words), then 4*N bytes MSB-first per
// word, optionally followed by an XOR checksum byte.
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHK state, XOR accumulator
// and the sticky err flag; without it err is tied low).
// rst_n is synchronous and active-high despite its name.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // A length byte of zero stands for a full memory image.
  localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_AFTER_LAST = S_CHK;
`else
  localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [1:0]        r_idx;
  logic [8:0]        r_remaining;

  logic w_ready;
  logic w_accept;
  logic w_last_word;

  // Ready depends on state only, so there is no valid->ready path.
  assign w_ready     = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_last_word = (r_remaining == 9'd1);

  assign bus.in_ready = w_ready;
  assign bus.mem_a    = r_addr;
  assign bus.mem_d    = r_word;
  assign bus.mem_we   = (r_state == S_WRITE);
  assign busy         = (r_state != S_IDLE);
  assign cpu_hold     = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);

  // Main loader FSM: length capture, word assembly, one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LEN;
            r_addr      <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_remaining <= (bus.in_data == 8'd0) ? DEPTH_CNT : {1'b0, bus.in_data};
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word <= {r_word[23:0], bus.in_data};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // Address wraps naturally, so an oversize image overwrites from 0.
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 9'd1;
          r_state     <= w_last_word ? S_AFTER_LAST : S_DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_err;

  // Running XOR of data bytes; err is sticky until the next start.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_xor <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_xor <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_DATA && w_accept) begin
      r_xor <= r_xor ^ bus.in_data;
    end else if (r_state == S_CHK && w_accept && (bus.in_data != r_xor)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Builds byte streams from word lists, drives them
// with several valid patterns and compares the observed memory writes, done
// timing and flags against a list-level model of the loader.
// Optional feature macro: LOADER_CHECKSUM_EN (enables the checksum scenario).
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] wr_a[$];
  logic [31:0]       wr_d[$];

  // Write-port monitor: logs every cycle with the strobe high.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_a);
      wr_d.push_back(bus.mem_d);
    end
  end

  // Stream builder: length byte, MSB-first words, optional XOR checksum.
  function automatic byte_q_t make_stream(input logic [7:0] n_field, input word_q_t words,
                                          input bit bad_chk);
    byte_q_t s;
    logic [7:0] x;
    x = 8'h00;
    s.push_back(n_field);
    foreach (words[k]) begin
      for (int b = 3; b >= 0; b--) begin
        s.push_back(words[k][b*8 +: 8]);
        x = x ^ words[k][b*8 +: 8];
      end
    end
    if (CHK_EN != 0) s.push_back(bad_chk ? (x ^ 8'h01) : x);
    return s;
  endfunction

  function automatic int words_of(input logic [7:0] n_field);
    return (n_field == 8'd0) ? DEPTH : int'(n_field);
  endfunction

  // Driver: start, offer bytes per valid pattern (0 held, 1 toggled, 2 random
  // with random start noise), stop at done or after a cycle budget.
  task automatic run_load(input byte_q_t s, input int mode, output int done_cyc,
                          output int hold_bad, output int consumed, output logic err_at_done,
                          output logic post_busy, output logic post_done);
    int   idx;
    int   cyc;
    bit   fin;
    logic rdy;
    idx = 0; cyc = 0; fin = 0;
    done_cyc = -1; hold_bad = 0; err_at_done = 1'bx;
    wr_a.delete(); wr_d.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (idx < s.size()) begin
        case (mode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = (cyc % 2 == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = bus.in_valid ? s[idx] : 8'($urandom);
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
      end
      if (mode == 2) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      rdy = bus.in_ready;
      if (cpu_hold !== 1'b1 || busy !== 1'b1) hold_bad++;
      if (done === 1'b1) begin
        done_cyc = cyc; fin = 1; err_at_done = err; start = 1'b0;
      end
      @(posedge clk);
      if (bus.in_valid && rdy) idx++;
      #1;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    consumed = idx;
    @(negedge clk);
    post_busy = busy;
    post_done = done;
    @(posedge clk); #1;
    $display("load: bytes=%0d mode=%0d consumed=%0d writes=%0d done_cyc=%0d err=%b",
             s.size(), mode, consumed, wr_a.size(), done_cyc, err_at_done);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.mem_a !== '0) begin n_errors++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    n_checks++; if (bus.mem_d !== 32'h0) begin n_errors++; $display("FAIL reset_mem_d: got %h want 0", bus.mem_d); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL idle_no_start: busy=%b ready=%b want 0 0", busy, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("reset: outputs sampled");
  endtask

  task automatic test_basic_and_backpressure;
    word_q_t w;
    byte_q_t s;
    int dc, hb, cons, dc0;
    logic e, pb, pd;
    w = '{32'h24080005, 32'h00000008};
    s = make_stream(8'h02, w, 1'b0);
    for (int mode = 0; mode < 2; mode++) begin
      run_load(s, mode, dc, hb, cons, e, pb, pd);
      n_checks++;
      if (wr_a.size() !== 2) begin n_errors++; $display("FAIL basic_nwrites(mode %0d): got %0d want 2", mode, wr_a.size()); end
      for (int k = 0; k < 2 && k < wr_a.size(); k++) begin
        n_checks++;
        if (wr_a[k] !== ADDR_W'(k) || wr_d[k] !== w[k])
          begin n_errors++; $display("FAIL basic_write%0d(mode %0d): got a=%0d d=%h want a=%0d d=%h", k, mode, wr_a[k], wr_d[k], k, w[k]); end
      end
      n_checks++;
      if (mode == 0) begin
        dc0 = dc;
        if (dc !== 12 + CHK_EN) begin n_errors++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, 12 + CHK_EN); end
      end else begin
        if (dc == -1 || dc <= dc0) begin n_errors++; $display("FAIL bp_done_delay: got %0d want >%0d", dc, dc0); end
      end
      n_checks++; if (hb !== 0) begin n_errors++; $display("FAIL basic_hold(mode %0d): %0d low cycles want 0", mode, hb); end
      n_checks++; if (cons !== s.size()) begin n_errors++; $display("FAIL basic_consumed(mode %0d): got %0d want %0d", mode, cons, s.size()); end
      n_checks++; if (pb !== 1'b0 || pd !== 1'b0) begin n_errors++; $display("FAIL basic_after_done(mode %0d): busy=%b done=%b want 0 0", mode, pb, pd); end
      n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL basic_err(mode %0d): got %b want 0", mode, e); end
    end
  endtask

  task automatic test_len0_wrap;
    word_q_t w;
    byte_q_t s;
    int dc, hb, cons, nw;
    logic e, pb, pd;
    logic [7:0] nf;
    for (int pass = 0; pass < 2; pass++) begin
      nf = (pass == 0) ? 8'h00 : 8'h21;
      nw = words_of(nf);
      w.delete();
      for (int k = 0; k < nw; k++) w.push_back($urandom);
      s = make_stream(nf, w, 1'b0);
      run_load(s, 0, dc, hb, cons, e, pb, pd);
      n_checks++;
      if (wr_a.size() !== nw) begin n_errors++; $display("FAIL wrap_nwrites(N=%0d): got %0d want %0d", nf, wr_a.size(), nw); end
      for (int k = 0; k < nw && k < wr_a.size(); k++) begin
        n_checks++;
        if (wr_a[k] !== ADDR_W'(k % DEPTH) || wr_d[k] !== w[k])
          begin n_errors++; $display("FAIL wrap_write%0d: got a=%0d d=%h want a=%0d d=%h", k, wr_a[k], wr_d[k], k % DEPTH, w[k]); end
      end
      n_checks++;
      if (dc !== 2 + 5 * nw + CHK_EN) begin n_errors++; $display("FAIL wrap_done_cycle(N=%0d): got %0d want %0d", nf, dc, 2 + 5 * nw + CHK_EN); end
      n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %b want 0", e); end
    end
  endtask

  task automatic test_reset_mid_word;
    word_q_t w;
    byte_q_t s;
    int dc, hb, cons;
    logic e, pb, pd;
    wr_a.delete(); wr_d.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h01;
    @(posedge clk); #1;
    bus.in_data = 8'hAB;
    @(posedge clk); #1;
    bus.in_data = 8'hCD;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0)
      begin n_errors++; $display("FAIL midreset_idle: busy=%b hold=%b ready=%b we=%b want 0 0 0 0", busy, cpu_hold, bus.in_ready, bus.mem_we); end
    repeat (6) @(negedge clk);
    n_checks++; if (wr_a.size() !== 0) begin n_errors++; $display("FAIL midreset_nowrite: got %0d writes want 0", wr_a.size()); end
    @(posedge clk); #1;
    $display("midreset: partial word abandoned");
    w = '{32'($urandom)};
    s = make_stream(8'h01, w, 1'b0);
    run_load(s, 0, dc, hb, cons, e, pb, pd);
    n_checks++;
    if (wr_a.size() !== 1 || wr_a[0] !== '0 || wr_d[0] !== w[0])
      begin n_errors++; $display("FAIL midreset_reload: nwr=%0d a=%0d d=%h want 1 0 %h", wr_a.size(), wr_a[0], wr_d[0], w[0]); end
  endtask

  task automatic test_random;
    word_q_t w;
    byte_q_t s;
    int dc, hb, cons, nw;
    logic e, pb, pd, want_err;
    logic [7:0] nf;
    bit bad;
    for (int t = 0; t < 8; t++) begin
      nf  = 8'($urandom_range(0, 40));
      nw  = words_of(nf);
      bad = 1'($urandom_range(0, 1));
      want_err = (CHK_EN != 0) && bad;
      w.delete();
      for (int k = 0; k < nw; k++) w.push_back($urandom);
      s = make_stream(nf, w, bad);
      run_load(s, 2, dc, hb, cons, e, pb, pd);
      n_checks++;
      if (wr_a.size() !== nw) begin n_errors++; $display("FAIL rand%0d_nwrites: got %0d want %0d", t, wr_a.size(), nw); end
      for (int k = 0; k < nw && k < wr_a.size(); k++) begin
        n_checks++;
        if (wr_a[k] !== ADDR_W'(k % DEPTH) || wr_d[k] !== w[k])
          begin n_errors++; $display("FAIL rand%0d_write%0d: got a=%0d d=%h want a=%0d d=%h", t, k, wr_a[k], wr_d[k], k % DEPTH, w[k]); end
      end
      n_checks++;
      if (dc == -1 || dc < 2 + 5 * nw + CHK_EN) begin n_errors++; $display("FAIL rand%0d_done: got %0d want >=%0d", t, dc, 2 + 5 * nw + CHK_EN); end
      n_checks++; if (cons !== s.size()) begin n_errors++; $display("FAIL rand%0d_consumed: got %0d want %0d", t, cons, s.size()); end
      n_checks++; if (e !== want_err) begin n_errors++; $display("FAIL rand%0d_err: got %b want %b", t, e, want_err); end
      n_checks++; if (hb !== 0 || pb !== 1'b0) begin n_errors++; $display("FAIL rand%0d_hold: low=%0d post_busy=%b want 0 0", t, hb, pb); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    byte_q_t s;
    int dc, hb, cons;
    logic e, pb, pd;
    for (int pass = 0; pass < 2; pass++) begin
      s = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      if (pass == 1) s[5] = 8'h45;
      run_load(s, 0, dc, hb, cons, e, pb, pd);
      n_checks++;
      if (e !== 1'(pass)) begin n_errors++; $display("FAIL chk%0d_err: got %b want %0d", pass, e, pass); end
      n_checks++;
      if (err !== 1'(pass)) begin n_errors++; $display("FAIL chk%0d_sticky: got %b want %0d", pass, err, pass); end
      n_checks++;
      if (wr_a.size() !== 1 || wr_d[0] !== 32'h11223344)
        begin n_errors++; $display("FAIL chk%0d_write: nwr=%0d d=%h want 1 11223344", pass, wr_a.size(), wr_d[0]); end
      n_checks++;
      if (dc !== 8) begin n_errors++; $display("FAIL chk%0d_done_cycle: got %0d want 8", pass, dc); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_backpressure();
    test_len0_wrap();
    test_reset_mid_word();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
